// File: rtl/spi_master_fifo.sv
// Soft SPI master with CPOL/CPHA/bit-order select, programmable SCLK divider and a TX FIFO.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise RX is a single holding register.
module spi_master_fifo #(
  parameter int unsigned NUM_CS     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              irq,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         ctrl_q, div_q;
  logic [NUM_CS-1:0]  csel_q;
  logic               txovf_q, rxovr_q;
  logic [7:0]         tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]      tx_wp_q, tx_rp_q;
  logic [AW:0]        tx_cnt_q;
  logic               cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [7:0]         bdiv_q, bdiv_d, hcnt_q, hcnt_d;
  logic [4:0]         edge_q, edge_d;
  logic               sclk_q, sclk_d, mosi_q, mosi_d;
  logic [7:0]         txsr_q, txsr_d, rxsr_q, rxsr_d;
  logic               tx_pop, rx_push, rx_pop, rx_avail, rx_ovr_set;
  logic [7:0]         rx_head, csel_rd, tx_head;

  logic wr, wr_data, rd_data, tx_full, tx_empty, tx_push, busy;
  assign wr       = cs & we;
  assign wr_data  = wr && (addr == 3'd0);
  assign rd_data  = cs && !we && (addr == 3'd0);
  assign tx_full  = (tx_cnt_q == CNT_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = wr_data & ~tx_full;
  assign busy     = (state_q != IDLE);
  assign tx_head  = tx_mem_q[tx_rp_q];

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    bdiv_d  = bdiv_q;
    hcnt_d  = hcnt_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    txsr_d  = txsr_q;
    rxsr_d  = rxsr_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state_q)
      IDLE: if (ctrl_q[7] && !tx_empty) begin
        tx_pop  = 1'b1;
        cpol_d  = ctrl_q[0];
        cpha_d  = ctrl_q[1];
        lsb_d   = ctrl_q[2];
        bdiv_d  = div_q;
        hcnt_d  = div_q;
        edge_d  = '0;
        sclk_d  = ctrl_q[0];
        txsr_d  = tx_head;
        // CPHA=0 must present the first bit before the leading edge
        if (!ctrl_q[1]) begin
          mosi_d = ctrl_q[2] ? tx_head[0] : tx_head[7];
          txsr_d = ctrl_q[2] ? {1'b0, tx_head[7:1]} : {tx_head[6:0], 1'b0};
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d = bdiv_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 5'd1;
          if (cpha_q ? !edge_d[0] : edge_d[0])
            rxsr_d = lsb_q ? {spi_miso, rxsr_q[7:1]} : {rxsr_q[6:0], spi_miso};
          if (cpha_q ? edge_d[0] : (!edge_d[0] && edge_d != 5'd16)) begin
            mosi_d = lsb_q ? txsr_q[0] : txsr_q[7];
            txsr_d = lsb_q ? {1'b0, txsr_q[7:1]} : {txsr_q[6:0], 1'b0};
          end
          if (edge_d == 5'd16) state_d = DONE;
        end
      end
      DONE: begin
        rx_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      bdiv_q  <= '0;
      hcnt_q  <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      txsr_q  <= '0;
      rxsr_q  <= '0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      bdiv_q  <= bdiv_d;
      hcnt_q  <= hcnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      txsr_q  <= txsr_d;
      rxsr_q  <= rxsr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (AW+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (AW+1)'(1);
    end
  end

`ifdef SPI_RX_FIFO_EN
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wp_q, rx_rp_q;
  logic [AW:0]   rx_cnt_q;
  logic          rx_full, rx_wr;
  assign rx_full    = (rx_cnt_q == CNT_FULL);
  assign rx_avail   = (rx_cnt_q != '0);
  assign rx_head    = rx_mem_q[rx_rp_q];
  assign rx_pop     = rd_data & rx_avail;
  assign rx_wr      = rx_push & ~rx_full;
  assign rx_ovr_set = rx_push & rx_full;

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wp_q] <= rxsr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
      if (rx_wr && !rx_pop)      rx_cnt_q <= rx_cnt_q + (AW+1)'(1);
      else if (!rx_wr && rx_pop) rx_cnt_q <= rx_cnt_q - (AW+1)'(1);
    end
  end
`else
  logic [7:0] rx_hold_q;
  logic       rx_avail_q;
  assign rx_avail   = rx_avail_q;
  assign rx_head    = rx_hold_q;
  assign rx_pop     = rd_data & rx_avail_q;
  assign rx_ovr_set = rx_push & rx_avail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_hold_q  <= '0;
      rx_avail_q <= 1'b0;
    end else if (rx_push) begin
      rx_hold_q  <= rxsr_q;
      rx_avail_q <= 1'b1;
    end else if (rx_pop) begin
      rx_avail_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      csel_q  <= '0;
      div_q   <= DIV_RESET;
      txovf_q <= 1'b0;
      rxovr_q <= 1'b0;
    end else begin
      if (wr && addr == 3'd2) ctrl_q <= din & 8'h9F;
      if (wr && addr == 3'd3) csel_q <= din[NUM_CS-1:0];
      if (wr && addr == 3'd4) div_q  <= din;
      if (wr && addr == 3'd1) begin
        if (din[5]) txovf_q <= 1'b0;
        if (din[4]) rxovr_q <= 1'b0;
      end
      if (wr_data && tx_full) txovf_q <= 1'b1;
      if (rx_ovr_set)         rxovr_q <= 1'b1;
    end
  end

  always_comb begin
    csel_rd = '0;
    csel_rd[NUM_CS-1:0] = csel_q;
  end

  always_comb begin
    dout = '0;
    case (addr)
      3'd0:    dout = rx_avail ? rx_head : 8'd0;
      3'd1:    dout = {2'b00, txovf_q, rxovr_q, rx_avail, tx_empty, tx_full, busy};
      3'd2:    dout = ctrl_q;
      3'd3:    dout = csel_rd;
      3'd4:    dout = div_q;
      default: dout = '0;
    endcase
  end

  assign irq      = (ctrl_q[3] & tx_empty & ~busy) | (ctrl_q[4] & rx_avail);
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = ~csel_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// Scoreboard bench for spi_master_fifo: register reads are checked by a monitor against queued
// expectations; pin-level behaviour is checked directly. Follows SPI_RX_FIFO_EN if defined.
module tb_spi_master_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0, we = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       irq, spi_sclk, spi_mosi, spi_miso;
  logic [1:0] spi_cs_n;

  int checks = 0;
  int failures = 0;
  int sclk_rises = 0;

  logic       loopback = 1'b1;
  logic       cur_cpha = 1'b0, cur_lsb = 1'b0;
  logic [7:0] sl_tx = '0, sl_rx = '0;
  int         sl_e = 0;
  logic       cs_prev = 1'b1;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] mask;
    string      name;
  } sb_t;
  sb_t sb[$];

  spi_master_fifo #(.NUM_CS(2), .FIFO_DEPTH(4), .DIV_RESET(8'd3)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .irq(irq), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  function automatic logic slave_bit(int e, logic cpha, logic lsb, logic [7:0] tx);
    int idx;
    idx = cpha ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
    if (idx > 7) idx = 7;
    return lsb ? tx[idx] : tx[7 - idx];
  endfunction

  assign spi_miso = loopback ? spi_mosi : slave_bit(sl_e, cur_cpha, cur_lsb, sl_tx);

  // Slave restarts its bit count whenever its select falls
  always @(spi_cs_n[0] or spi_sclk) begin
    if (spi_cs_n[0] === 1'b0) begin
      if (cs_prev) begin
        sl_e  = 0;
        sl_rx = '0;
      end else begin
        sl_e++;
        if (cur_cpha ? (sl_e % 2 == 0) : (sl_e % 2 == 1))
          sl_rx = cur_lsb ? {spi_mosi, sl_rx[7:1]} : {sl_rx[6:0], spi_mosi};
      end
    end
    cs_prev = spi_cs_n[0];
  end

  always @(posedge spi_sclk) sclk_rises++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cs === 1'b1 && we === 1'b0) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow actual=read expected=none addr=%0d", addr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.mask != 8'h00) check(e.name, dout & e.mask, e.exp & e.mask);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input logic [7:0] mask,
                        input string name);
    sb_t e;
    e.exp = exp; e.mask = mask; e.name = name;
    sb.push_back(e);
    cs = 1'b1; we = 1'b0; addr = a;
    cyc();
    cs = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] txb, rxb;
    logic [1:0] m;

    // Reset values
    idle(3);
    check("rst_sclk", {7'd0, spi_sclk}, 8'h00);
    check("rst_mosi", {7'd0, spi_mosi}, 8'h00);
    check("rst_csn", {6'd0, spi_cs_n}, 8'h03);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rst = 1'b1;
    cyc();
    bus_rd(3'd1, 8'h04, 8'hFF, "rst_status");
    bus_rd(3'd4, 8'h03, 8'hFF, "rst_div");
    bus_rd(3'd2, 8'h00, 8'hFF, "rst_ctrl");
    bus_rd(3'd3, 8'h00, 8'hFF, "rst_csel");
    bus_wr(3'd3, 8'hFF);
    bus_rd(3'd3, 8'h03, 8'hFF, "csel_width");
    check("csel_pins", {6'd0, spi_cs_n}, 8'h00);
    bus_wr(3'd7, 8'h55);
    bus_rd(3'd7, 8'h00, 8'hFF, "unused_addr");

    // Mode 0 loopback, DIV=0: cycle-exact status and SCLK
    bus_wr(3'd2, 8'h80);
    bus_wr(3'd4, 8'h00);
    bus_wr(3'd3, 8'h01);
    bus_wr(3'd0, 8'hA5);
    for (int k = 1; k <= 19; k++) begin
      check("m0_sclk", {7'd0, spi_sclk}, (k >= 3 && k <= 17 && k % 2 == 1) ? 8'h01 : 8'h00);
      bus_rd(3'd1, (k == 1) ? 8'h00 : (k == 19) ? 8'h0C : 8'h05, 8'hFF, "m0_status");
    end
    bus_rd(3'd0, 8'hA5, 8'hFF, "m0_data");
    bus_rd(3'd1, 8'h04, 8'hFF, "m0_status_after");

    // DIV=2: first edge and RXAVAIL latency
    bus_wr(3'd4, 8'h02);
    bus_wr(3'd0, 8'h5C);
    for (int k = 1; k <= 51; k++) begin
      if (k == 4 || k == 8) check("div2_sclk_lo", {7'd0, spi_sclk}, 8'h00);
      if (k == 5 || k == 7) check("div2_sclk_hi", {7'd0, spi_sclk}, 8'h01);
      bus_rd(3'd1, (k == 51) ? 8'h08 : 8'h00, 8'h08, "div2_rxavail");
    end
    bus_rd(3'd0, 8'h5C, 8'hFF, "div2_data");

    // TX overflow with EN=0, then drain with one IDLE cycle between bytes
    bus_wr(3'd4, 8'h00);
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd0, 8'h11);
    bus_wr(3'd0, 8'h22);
    bus_wr(3'd0, 8'h33);
    bus_wr(3'd0, 8'h44);
    bus_wr(3'd0, 8'h55);
    bus_rd(3'd1, 8'h22, 8'hFF, "txovf_status");
    sclk_rises = 0;
    bus_wr(3'd2, 8'h80);
    for (int k = 1; k <= 73; k++) begin
      bus_rd(3'd1, (k == 1 || k == 19 || k == 37 || k == 55 || k == 73) ? 8'h00 : 8'h01,
             8'h01, "txovf_busy");
    end
    check("txovf_pulses", 8'(sclk_rises), 8'd32);
`ifdef SPI_RX_FIFO_EN
    bus_rd(3'd0, 8'h11, 8'hFF, "txovf_rx0");
    bus_rd(3'd0, 8'h22, 8'hFF, "txovf_rx1");
    bus_rd(3'd0, 8'h33, 8'hFF, "txovf_rx2");
    bus_rd(3'd0, 8'h44, 8'hFF, "txovf_rx3");
    bus_rd(3'd1, 8'h24, 8'hFF, "txovf_status_end");
`else
    bus_rd(3'd0, 8'h44, 8'hFF, "txovf_rxlast");
    bus_rd(3'd1, 8'h34, 8'hFF, "txovf_status_end");
`endif
    bus_wr(3'd1, 8'h30);
    bus_rd(3'd1, 8'h04, 8'hFF, "clear_flags");

    // RX overrun: five bytes, nothing read
    bus_wr(3'd0, 8'h61);
    bus_wr(3'd0, 8'h62);
    bus_wr(3'd0, 8'h63);
    bus_wr(3'd0, 8'h64);
    bus_wr(3'd0, 8'h65);
    idle(100);
    bus_rd(3'd1, 8'h1C, 8'hFF, "rxovr_status");
`ifdef SPI_RX_FIFO_EN
    bus_rd(3'd0, 8'h61, 8'hFF, "rxovr_rx0");
    bus_rd(3'd0, 8'h62, 8'hFF, "rxovr_rx1");
    bus_rd(3'd0, 8'h63, 8'hFF, "rxovr_rx2");
    bus_rd(3'd0, 8'h64, 8'hFF, "rxovr_rx3");
`else
    bus_rd(3'd0, 8'h65, 8'hFF, "rxovr_rxlast");
`endif
    bus_rd(3'd1, 8'h14, 8'hFF, "rxovr_drained");
    bus_wr(3'd1, 8'h10);
    bus_rd(3'd1, 8'h04, 8'hFF, "rxovr_clear");
    bus_rd(3'd0, 8'h00, 8'hFF, "rx_empty_read");

    // Four clock modes x bit order against an external slave
    loopback = 1'b0;
    bus_wr(3'd4, 8'h01);
    for (int c = 0; c < 8; c++) begin
      m = 2'(c % 4);
      cur_cpha = m[1];
      cur_lsb = (c >= 4);
      bus_wr(3'd3, 8'h00);
      bus_wr(3'd2, 8'h80 | (cur_lsb ? 8'h04 : 8'h00) | {6'd0, m});
      bus_wr(3'd0, 8'h00);
      idle(40);
      bus_rd(3'd0, 8'h00, 8'h00, "flush");
      check("mode_sclk_rest", {7'd0, spi_sclk}, {7'd0, m[0]});
      for (int p = 0; p < 2; p++) begin
        txb = (p == 0) ? 8'hC3 : 8'h1D;
        rxb = (p == 0) ? 8'h3C : 8'hB4;
        bus_wr(3'd3, 8'h00);
        sl_tx = rxb;
        bus_wr(3'd3, 8'h01);
        bus_wr(3'd0, txb);
        idle(40);
        bus_rd(3'd0, rxb, 8'hFF, "mode_master_rx");
        check("mode_slave_rx", sl_rx, txb);
        check("mode_sclk_idle", {7'd0, spi_sclk}, {7'd0, m[0]});
      end
    end
    loopback = 1'b1;

    // IRQ rises the cycle after DONE
    bus_wr(3'd4, 8'h00);
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd0, 8'h5A);
    bus_wr(3'd2, 8'h88);
    for (int k = 1; k <= 20; k++) begin
      check("irq_timing", {7'd0, irq}, (k >= 19) ? 8'h01 : 8'h00);
      cyc();
    end
    bus_rd(3'd0, 8'h5A, 8'hFF, "irq_data");

    // Reset at edge 7 of the next byte
    bus_wr(3'd3, 8'h03);
    bus_wr(3'd0, 8'h96);
    idle(8);
    check("pre_rst_sclk", {7'd0, spi_sclk}, 8'h01);
    check("pre_rst_mosi", {7'd0, spi_mosi}, 8'h01);
    check("pre_rst_csn", {6'd0, spi_cs_n}, 8'h00);
    rst = 1'b0;
    #1;
    check("midrst_sclk", {7'd0, spi_sclk}, 8'h00);
    check("midrst_mosi", {7'd0, spi_mosi}, 8'h00);
    check("midrst_csn", {6'd0, spi_cs_n}, 8'h03);
    check("midrst_irq", {7'd0, irq}, 8'h00);
    idle(2);
    rst = 1'b1;
    cyc();
    bus_rd(3'd1, 8'h04, 8'hFF, "post_rst_status");
    bus_rd(3'd4, 8'h03, 8'hFF, "post_rst_div");
    bus_rd(3'd0, 8'h00, 8'hFF, "post_rst_data");
    idle(2);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
